coffee_order_scheduler: RTL and testbench

Order front-end for the coffee brewer FSM. Takes drink orders from two requesters, the front panel and the remote app, through valid/ready handshakes. Arbitrates between them round-robin and buffers orders in a small FIFO. Sequences the brewer one order at a time with a one-cycle start pulse and a held drink select, then waits for the brewer's done, with a watchdog timeout.

---
 rtl/coffee_order_scheduler.sv | 173 +++++++++++++++++
 tb/tb_coffee_order_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_order_scheduler.sv
// Order front-end for the coffee brewer: two-port round-robin intake, order FIFO, brew sequencer.
// Optional served-order counter is built only when ORDER_STATS_EN is defined.
module coffee_order_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       panel_valid,
  input  logic [1:0]                 panel_sel,
  output logic                       panel_ready,
  input  logic                       app_valid,
  input  logic [1:0]                 app_sel,
  output logic                       app_ready,
  output logic                       brew_start,
  output logic [1:0]                 brew_sel,
  input  logic                       brew_done,
  output logic                       order_done,
  output logic                       done_src,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       timeout_err,
  input  logic                       err_clear,
  output logic [15:0]                served_total,
  output logic [2:0]                 dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RELEASE   = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  // Handshake: an order transfers on a port in any cycle where valid and ready
  // are both high at the rising edge; ready depends only on valid and the
  // registered free space, never on the pop happening in that cycle.

  state_t          state;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free_slots;
  logic            rr_app;
  logic            src_q;
  logic [TW-1:0]   wd_cnt;
  logic            panel_acc;
  logic            app_acc;
  logic            first_is_app;
  logic [2:0]      first_entry;
  logic [2:0]      second_entry;
  logic [1:0]      n_push;
  logic            pop;
  logic [2:0]      head;

  assign free_slots  = CW'(DEPTH) - count;
  assign queue_count = count;
  assign head        = mem[rd_ptr];
  assign pop         = (state == S_LAUNCH);
  assign busy        = (state != S_IDLE);
  assign dbg_state   = state;

  always_comb begin
    panel_ready = 1'b0;
    app_ready   = 1'b0;
    if (free_slots >= CW'(2)) begin
      panel_ready = 1'b1;
      app_ready   = 1'b1;
    end else if (free_slots == CW'(1)) begin
      // One slot left: a lone requester gets it, a contested slot goes to the favoured port.
      panel_ready = panel_valid && (!app_valid || !rr_app);
      app_ready   = app_valid && (!panel_valid || rr_app);
    end
  end

  assign panel_acc    = panel_valid && panel_ready;
  assign app_acc      = app_valid && app_ready;
  assign first_is_app = app_acc && (!panel_acc || rr_app);
  assign first_entry  = first_is_app ? {1'b1, app_sel} : {1'b0, panel_sel};
  assign second_entry = first_is_app ? {1'b0, panel_sel} : {1'b1, app_sel};
  assign n_push       = {1'b0, panel_acc} + {1'b0, app_acc};

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_ptr] <= first_entry;
    if (n_push == 2'd2) mem[wr_ptr + AW'(1)] <= second_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_app <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
      if (panel_valid && app_valid) rr_app <= ~rr_app;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      brew_start  <= 1'b0;
      brew_sel    <= 2'b00;
      order_done  <= 1'b0;
      done_src    <= 1'b0;
      timeout_err <= 1'b0;
      src_q       <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      brew_start <= 1'b0;
      order_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state      <= S_LAUNCH;
            brew_start <= 1'b1;
            brew_sel   <= head[1:0];
            src_q      <= head[2];
          end
        end
        S_LAUNCH: begin
          state  <= S_WAIT_DONE;
          wd_cnt <= '0;
        end
        S_WAIT_DONE: begin
          if (brew_done) begin
            order_done <= 1'b1;
            done_src   <= src_q;
            state      <= S_RELEASE;
          end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
            state       <= S_ERROR;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
        end
        S_RELEASE: begin
          // A level-style done must drop before the next order can complete.
          if (!brew_done) state <= S_IDLE;
        end
        S_ERROR: begin
          if (err_clear) begin
            state       <= S_IDLE;
            timeout_err <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ORDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_total <= 16'h0000;
    end else if ((state == S_WAIT_DONE) && brew_done && (served_total != 16'hFFFF)) begin
      served_total <= served_total + 16'h0001;
    end
  end
`else
  assign served_total = 16'h0000;
`endif

endmodule

// File: tb/tb_coffee_order_scheduler.sv
// Bench for coffee_order_scheduler: vector table for intake/fill, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_coffee_order_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;
  localparam int CW      = $clog2(DEPTH + 1);
`ifdef ORDER_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          panel_valid;
  logic [1:0]    panel_sel;
  logic          panel_ready;
  logic          app_valid;
  logic [1:0]    app_sel;
  logic          app_ready;
  logic          brew_start;
  logic [1:0]    brew_sel;
  logic          brew_done;
  logic          order_done;
  logic          done_src;
  logic          busy;
  logic [CW-1:0] queue_count;
  logic          timeout_err;
  logic          err_clear;
  logic [15:0]   served_total;
  logic [2:0]    dbg_state;

  coffee_order_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .panel_valid  (panel_valid),
    .panel_sel    (panel_sel),
    .panel_ready  (panel_ready),
    .app_valid    (app_valid),
    .app_sel      (app_sel),
    .app_ready    (app_ready),
    .brew_start   (brew_start),
    .brew_sel     (brew_sel),
    .brew_done    (brew_done),
    .order_done   (order_done),
    .done_src     (done_src),
    .busy         (busy),
    .queue_count  (queue_count),
    .timeout_err  (timeout_err),
    .err_clear    (err_clear),
    .served_total (served_total),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    panel_valid = 1'b0;
    panel_sel   = 2'b00;
    app_valid   = 1'b0;
    app_sel     = 2'b00;
    brew_done   = 1'b0;
    err_clear   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic          pv;
    logic          av;
    logic          pr;
    logic          ar;
    logic [CW-1:0] cnt;
    logic          bs;
    logic          bsy;
  } vec_t;

  vec_t tbl[7];

  // scoreboard state for the randomized phase
  logic [2:0] exp_q[$];
  logic       rr_app_m;
  logic       pend;
  logic       last_src;
  logic       prev_bs;
  logic       epr;
  logic       ear;
  logic       pa;
  logic       aa;
  logic [2:0] ent;
  int         free_m;
  int         od_cnt;
  int         d_from;
  int         d_to;
  int         rate;
  int         od;
  int         bs_cnt;

  initial begin
    // both ports valid every cycle, brewer silent: fill, contested last slot, full
    tbl[0] = '{pv:1, av:1, pr:1, ar:1, cnt:0, bs:0, bsy:0};
    tbl[1] = '{pv:1, av:1, pr:1, ar:1, cnt:2, bs:0, bsy:0};
    tbl[2] = '{pv:1, av:1, pr:0, ar:0, cnt:4, bs:1, bsy:1};
    tbl[3] = '{pv:1, av:1, pr:0, ar:1, cnt:3, bs:0, bsy:1};
    tbl[4] = '{pv:1, av:1, pr:0, ar:0, cnt:4, bs:0, bsy:1};
    tbl[5] = '{pv:1, av:1, pr:0, ar:0, cnt:4, bs:0, bsy:1};
    tbl[6] = '{pv:0, av:0, pr:0, ar:0, cnt:4, bs:0, bsy:1};

    do_reset();
    #1;
    check("rst_count", queue_count, 0);
    check("rst_busy", busy, 0);
    check("rst_brew_start", brew_start, 0);
    check("rst_brew_sel", brew_sel, 0);
    check("rst_order_done", order_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_served", served_total, 0);
    tick();
    do_reset();

    panel_sel = 2'b01;
    app_sel   = 2'b10;
    for (int i = 0; i < 7; i++) begin
      panel_valid = tbl[i].pv;
      app_valid   = tbl[i].av;
      #1;
      check($sformatf("tbl%0d_panel_ready", i), panel_ready, tbl[i].pr);
      check($sformatf("tbl%0d_app_ready", i), app_ready, tbl[i].ar);
      check($sformatf("tbl%0d_count", i), queue_count, tbl[i].cnt);
      check($sformatf("tbl%0d_brew_start", i), brew_start, tbl[i].bs);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      if (i == 2) check("tbl2_brew_sel", brew_sel, 2'b01);
      tick();
    end

    // watchdog: WAIT_DONE entered in cycle 3, error visible in cycle 53
    for (int c = 7; c < 52; c++) tick();
    #1;
    check("wd_not_yet", timeout_err, 0);
    check("wd_sel_held", brew_sel, 2'b01);
    tick();
    #1;
    check("wd_err_rise", timeout_err, 1);
    check("wd_queue_held", queue_count, 4);
    check("wd_busy", busy, 1);
    brew_done = 1'b1;
    repeat (3) begin
      tick();
      #1;
      check("err_done_ignored", order_done, 0);
      check("err_sticky", timeout_err, 1);
    end
    brew_done = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1;
    check("clr_err_low", timeout_err, 0);
    check("clr_no_start", brew_start, 0);
    check("clr_no_done", order_done, 0);
    tick();
    #1;
    check("clr_launch", brew_start, 1);
    check("clr_launch_sel", brew_sel, 2'b10);
    tick();
    #1;
    check("clr_start_one_cycle", brew_start, 0);
    check("clr_count", queue_count, 3);

    // asynchronous reset in WAIT_DONE with 3 queued
    reset = 1'b1;
    #1;
    check("arst_count", queue_count, 0);
    check("arst_busy", busy, 0);
    check("arst_brew_start", brew_start, 0);
    check("arst_brew_sel", brew_sel, 0);
    tick();
    #1;
    check("arst_no_done", order_done, 0);
    do_reset();

    // single panel espresso, done 30 cycles after start
    panel_valid = 1'b1;
    panel_sel   = 2'b00;
    #1;
    check("t1_panel_ready", panel_ready, 1);
    tick();
    panel_valid = 1'b0;
    #1;
    check("t1_count", queue_count, 1);
    check("t1_no_start_yet", brew_start, 0);
    tick();
    #1;
    check("t1_start", brew_start, 1);
    check("t1_sel", brew_sel, 2'b00);
    check("t1_busy", busy, 1);
    repeat (30) tick();
    brew_done = 1'b1;
    tick();
    brew_done = 1'b0;
    #1;
    check("t1_order_done", order_done, 1);
    check("t1_done_src", done_src, 0);
    tick();
    #1;
    check("t1_done_pulse", order_done, 0);
    check("t1_idle", busy, 0);
    check("t1_served", served_total, STATS ? 32'd1 : 32'd0);

    // level done held 10 cycles, a second order waiting behind it
    panel_valid = 1'b1;
    panel_sel   = 2'b10;
    app_valid   = 1'b1;
    app_sel     = 2'b11;
    #1;
    check("t4_panel_ready", panel_ready, 1);
    check("t4_app_ready", app_ready, 1);
    tick();
    panel_valid = 1'b0;
    app_valid   = 1'b0;
    tick();
    #1;
    check("t4_start1", brew_start, 1);
    check("t4_sel1", brew_sel, 2'b10);
    tick();
    od     = 0;
    bs_cnt = 0;
    for (int t = 3; t < 16; t++) begin
      brew_done = (t >= 4) && (t <= 13);
      #1;
      if (order_done) begin
        od++;
        check("t4_src1", done_src, 0);
      end
      if (brew_start) bs_cnt++;
      tick();
    end
    brew_done = 1'b0;
    #1;
    check("t4_single_done", od, 1);
    check("t4_no_early_start", bs_cnt, 0);
    check("t4_start2", brew_start, 1);
    check("t4_sel2", brew_sel, 2'b11);
    tick();
    brew_done = 1'b1;
    tick();
    brew_done = 1'b0;
    #1;
    check("t4_order_done2", order_done, 1);
    check("t4_src2", done_src, 1);
    check("t4_served", served_total, STATS ? 32'd3 : 32'd0);

    // randomized traffic against the queue model
    do_reset();
    exp_q.delete();
    rr_app_m = 1'b0;
    pend     = 1'b0;
    last_src = 1'b0;
    prev_bs  = 1'b0;
    od_cnt   = 0;
    d_from   = -1;
    d_to     = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rate        = (cyc / 400) % 3;
      panel_valid = ($urandom_range(0, 3) <= rate);
      app_valid   = ($urandom_range(0, 3) <= rate);
      panel_sel   = 2'($urandom_range(0, 3));
      app_sel     = 2'($urandom_range(0, 3));
      brew_done   = (cyc >= d_from) && (cyc < d_to);
      #1;
      free_m = DEPTH - exp_q.size();
      epr = 1'b0;
      ear = 1'b0;
      if (free_m >= 2) begin
        epr = 1'b1;
        ear = 1'b1;
      end else if (free_m == 1) begin
        if (panel_valid && app_valid) begin
          epr = !rr_app_m;
          ear = rr_app_m;
        end else begin
          epr = panel_valid;
          ear = app_valid;
        end
      end
      check("rnd_panel_ready", panel_ready, epr);
      check("rnd_app_ready", app_ready, ear);
      check("rnd_count", queue_count, exp_q.size());
      if (brew_start) begin
        check("rnd_start_gap", prev_bs, 0);
        check("rnd_start_overlap", pend, 0);
        check("rnd_start_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          check("rnd_sel", brew_sel, ent[1:0]);
          last_src = ent[2];
        end
        pend   = 1'b1;
        d_from = cyc + $urandom_range(1, 6);
        d_to   = d_from + $urandom_range(1, 4);
      end
      if (order_done) begin
        check("rnd_done_pending", pend, 1);
        check("rnd_done_src", done_src, last_src);
        pend = 1'b0;
        od_cnt++;
      end
      prev_bs = brew_start;
      pa = panel_valid && epr;
      aa = app_valid && ear;
      if (pa && aa) begin
        if (rr_app_m) begin
          exp_q.push_back({1'b1, app_sel});
          exp_q.push_back({1'b0, panel_sel});
        end else begin
          exp_q.push_back({1'b0, panel_sel});
          exp_q.push_back({1'b1, app_sel});
        end
      end else if (pa) begin
        exp_q.push_back({1'b0, panel_sel});
      end else if (aa) begin
        exp_q.push_back({1'b1, app_sel});
      end
      if (panel_valid && app_valid) rr_app_m = ~rr_app_m;
      if (cyc == 2999) begin
        check("rnd_served", served_total, STATS ? 32'(od_cnt) : 32'd0);
        check("rnd_progress", od_cnt > 20, 1);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
